mfp_irq_ctrl: RTL

- 16-channel interrupt controller for the MFP68901 block. It arbitrates the timer pulses (T_O_PULSE of timers A–D) and the GPIP/serial event pulses onto a single CPU interrupt request.
- Holds the enable, pending, in-service and mask register pairs (A = channels 15..8, B = channels 7..0) plus the vector register.
- Runs the IACK vector handshake.
- Sits between the timer/GPIO sources and the CPU bus glue.

---
 rtl/mfp_irq_pkg.sv | 21 ++
 rtl/mfp_irq_prio_enc.sv | 16 +
 rtl/mfp_irq_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mfp_irq_pkg.sv
// mfp_irq_pkg: shared constants and types for the MFP68901 interrupt controller.
// Holds the register map, channel count, spurious vector nibble, the handshake
// state enum and the channel numbers of the timer A..D interrupt sources.
package mfp_irq_pkg;
  localparam int NCH = 16;
  localparam logic [3:0] SPUR_NIBBLE = 4'hF;
  localparam logic [3:0] A_IERA = 4'd0;
  localparam logic [3:0] A_IERB = 4'd1;
  localparam logic [3:0] A_IPRA = 4'd2;
  localparam logic [3:0] A_IPRB = 4'd3;
  localparam logic [3:0] A_ISRA = 4'd4;
  localparam logic [3:0] A_ISRB = 4'd5;
  localparam logic [3:0] A_IMRA = 4'd6;
  localparam logic [3:0] A_IMRB = 4'd7;
  localparam logic [3:0] A_VR   = 4'd8;
  localparam int CH_TIMER_A = 13;
  localparam int CH_TIMER_B = 8;
  localparam int CH_TIMER_C = 5;
  localparam int CH_TIMER_D = 4;
  typedef enum logic [1:0] {IDLE, VECT, WAIT_REL} state_t;
endpackage

// File: rtl/mfp_irq_prio_enc.sv
// mfp_irq_prio_enc: highest-set-bit encoder over the 16 interrupt channels.
// Ports: vec (channel bit vector), idx (index of highest set bit, 0 when none),
// vld (at least one bit set).
module mfp_irq_prio_enc
  import mfp_irq_pkg::*;
(
  input  logic [NCH-1:0] vec,
  output logic [3:0]     idx,
  output logic           vld
);
  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < NCH; i++) idx = vec[i] ? 4'(i) : idx;
  end
  assign vld = |vec;
endmodule

// File: rtl/mfp_irq_ctrl.sv
// mfp_irq_ctrl: 16-channel MFP68901 interrupt controller with IACK vector handshake.
// Ports: XCLK_I clock, RST sync active-high reset, IRQ_IN event pulses,
// REG_WE/REG_ADDR/DAT_I register write, DAT_O registered read data,
// IACK acknowledge level, IRQ request, VECTOR_O acknowledged vector,
// DTACK one-cycle vector-valid pulse.
// Optional: define MFP_IRQ_SPURIOUS_EN to answer an unqualified IACK with
// DTACK and vector {VR[7:4], SPUR_NIBBLE}.
module mfp_irq_ctrl
  import mfp_irq_pkg::*;
(
  input  logic           XCLK_I,
  input  logic           RST,
  input  logic [NCH-1:0] IRQ_IN,
  input  logic           REG_WE,
  input  logic [3:0]     REG_ADDR,
  input  logic [7:0]     DAT_I,
  output logic [7:0]     DAT_O,
  input  logic           IACK,
  output logic           IRQ,
  output logic [7:0]     VECTOR_O,
  output logic           DTACK
);
  logic [NCH-1:0] ier_q, ier_d, ipr_q, ipr_d, isr_q, isr_d, imr_q, imr_d;
  logic [7:0]     vr_q, vr_d, dat_q, dat_d;
  logic           irq_q, irq_d;
  state_t         state_q, state_d;
  logic           dtack_q, dtack_d;
  logic [7:0]     vec_q, vec_d;
  logic [3:0]     hv_q, hv_d;
  logic [8:0]     wsel;
  logic [NCH-1:0] cand, vect_bit;
  logic [3:0]     hp, hs;
  logic           cand_v, isr_v;

  assign cand = ipr_q & imr_q;

  mfp_irq_prio_enc u_cand_enc (.vec(cand),  .idx(hp), .vld(cand_v));
  mfp_irq_prio_enc u_isr_enc  (.vec(isr_q), .idx(hs), .vld(isr_v));

  // Register file: pending sets are applied last so a simultaneous event always
  // beats any clear; the vectored ISR set is applied after write clears.
  always_comb begin
    wsel     = REG_WE ? 9'(1) << REG_ADDR : 9'd0;
    vect_bit = (state_q == VECT) ? NCH'(1) << hv_q : '0;
    ier_d    = {wsel[A_IERA] ? DAT_I : ier_q[15:8], wsel[A_IERB] ? DAT_I : ier_q[7:0]};
    imr_d    = {wsel[A_IMRA] ? DAT_I : imr_q[15:8], wsel[A_IMRB] ? DAT_I : imr_q[7:0]};
    vr_d     = wsel[A_VR] ? DAT_I : vr_q;
    ipr_d    = (ipr_q & {wsel[A_IPRA] ? DAT_I : 8'hFF, wsel[A_IPRB] ? DAT_I : 8'hFF}
                & ier_d & ~vect_bit) | (IRQ_IN & ier_d);
    isr_d    = ((wsel[A_VR] && !DAT_I[3]) ? '0
                : isr_q & {wsel[A_ISRA] ? DAT_I : 8'hFF, wsel[A_ISRB] ? DAT_I : 8'hFF})
               | (vr_q[3] ? vect_bit : '0);
    irq_d    = cand_v && (!isr_v || hp > hs);
  end

  always_comb begin
    case (REG_ADDR)
      A_IERA:  dat_d = ier_q[15:8];
      A_IERB:  dat_d = ier_q[7:0];
      A_IPRA:  dat_d = ipr_q[15:8];
      A_IPRB:  dat_d = ipr_q[7:0];
      A_ISRA:  dat_d = isr_q[15:8];
      A_ISRB:  dat_d = isr_q[7:0];
      A_IMRA:  dat_d = imr_q[15:8];
      A_IMRB:  dat_d = imr_q[7:0];
      A_VR:    dat_d = vr_q;
      default: dat_d = 8'h00;
    endcase
  end

  always_ff @(posedge XCLK_I) begin
    if (RST) begin
      ier_q <= '0;
      ipr_q <= '0;
      isr_q <= '0;
      imr_q <= '0;
      vr_q  <= 8'h00;
      dat_q <= 8'h00;
      irq_q <= 1'b0;
    end else begin
      ier_q <= ier_d;
      ipr_q <= ipr_d;
      isr_q <= isr_d;
      imr_q <= imr_d;
      vr_q  <= vr_d;
      dat_q <= dat_d;
      irq_q <= irq_d;
    end
  end

  // Acknowledge handshake: the channel is latched as IACK is first seen so the
  // vector and the VECT-cycle pending clear refer to the same channel.
  always_comb begin
    state_d = state_q;
    dtack_d = 1'b0;
    vec_d   = vec_q;
    hv_d    = hv_q;
    case (state_q)
      IDLE: begin
        if (IACK && irq_q) begin
          state_d = VECT;
          dtack_d = 1'b1;
          hv_d    = hp;
          vec_d   = {vr_q[7:4], hp};
        end else if (IACK) begin
          state_d = WAIT_REL;
`ifdef MFP_IRQ_SPURIOUS_EN
          dtack_d = 1'b1;
          vec_d   = {vr_q[7:4], SPUR_NIBBLE};
`else
          dtack_d = 1'b0;
`endif
        end
      end
      VECT:     state_d = WAIT_REL;
      WAIT_REL: state_d = IACK ? WAIT_REL : IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge XCLK_I) begin
    if (RST) begin
      state_q <= IDLE;
      dtack_q <= 1'b0;
      vec_q   <= 8'h00;
      hv_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      dtack_q <= dtack_d;
      vec_q   <= vec_d;
      hv_q    <= hv_d;
    end
  end

  assign DAT_O    = dat_q;
  assign IRQ      = irq_q;
  assign VECTOR_O = vec_q;
  assign DTACK    = dtack_q;
endmodule
